copy_request_receiver: RTL and testbench

//  BRAM-side endpoint of the copy-token request interface. Takes the registered copy request
//  (address/byte-valid/offset/valid) from the copy-token selector and checks the requested bytes

---
 rtl/copy_request_receiver_pkg.sv | 37 +++
 rtl/copy_request_receiver_if.sv | 48 ++++
 rtl/copy_request_receiver_sync_fifo_fwft.sv | 71 +++++++
 rtl/copy_request_receiver.sv | 148 ++++++++++++++
 tb/tb_copy_request_receiver.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/copy_request_receiver_pkg.sv
// Shared types and constants for the copy-token request receiver: token layout,
// routing enum and a token packing helper.
package copy_request_receiver_pkg;

    localparam int TOKEN_W     = 33;
    localparam int ADDR_MSB    = 32;
    localparam int ADDR_LSB    = 24;
    localparam int BV_MSB      = 23;
    localparam int BV_LSB      = 16;
    localparam int OFF_MSB     = 15;
    localparam int OFF_LSB     = 0;

    localparam int LINE_ADDR_W = ADDR_MSB - ADDR_LSB + 1;
    localparam int BV_W        = BV_MSB - BV_LSB + 1;
    localparam int OFF_W       = OFF_MSB - OFF_LSB + 1;

    typedef logic [TOKEN_W-1:0] token_t;

    typedef enum logic [1:0] {
        ROUTE_NONE     = 2'd0,
        ROUTE_EVEN     = 2'd1,
        ROUTE_ODD      = 2'd2,
        ROUTE_UNSOLVED = 2'd3
    } route_e;

    function automatic token_t pack_token(input logic [LINE_ADDR_W-1:0] addr,
                                          input logic [BV_W-1:0]        bvalid,
                                          input logic [OFF_W-1:0]       offset);
        token_t t;
        t                   = '0;
        t[ADDR_MSB:ADDR_LSB] = addr;
        t[BV_MSB:BV_LSB]     = bvalid;
        t[OFF_MSB:OFF_LSB]   = offset;
        return t;
    endfunction

endpackage

// File: rtl/copy_request_receiver_if.sv
// Request, literal-write and FIFO read-side signals between the copy-token selector
// and the BRAM-side receiver. The receiver uses the slave modport.
interface copy_request_receiver_if
    import copy_request_receiver_pkg::*;
#(
    parameter int ADDR_W = LINE_ADDR_W
) ();

    logic               clear;
    logic [ADDR_W-1:0]  address_in;
    logic [BV_W-1:0]    bvalid_in;
    logic [OFF_W-1:0]   offset_in;
    logic               valid_in;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [BV_W-1:0]    wr_bvalid;

    logic [TOKEN_W-1:0] even_data;
    logic               even_valid;
    logic               even_rd;
    logic [TOKEN_W-1:0] odd_data;
    logic               odd_valid;
    logic               odd_rd;
    logic [TOKEN_W-1:0] unsolved_out;
    logic               unsolved_valid;
    logic               unsolved_rd;

    logic               stop;
    logic               overflow;

    modport slave (
        input  clear, address_in, bvalid_in, offset_in, valid_in,
        input  wr_en, wr_addr, wr_bvalid,
        input  even_rd, odd_rd, unsolved_rd,
        output even_data, even_valid, odd_data, odd_valid,
        output unsolved_out, unsolved_valid, stop, overflow
    );

    modport master (
        output clear, address_in, bvalid_in, offset_in, valid_in,
        output wr_en, wr_addr, wr_bvalid,
        output even_rd, odd_rd, unsolved_rd,
        input  even_data, even_valid, odd_data, odd_valid,
        input  unsolved_out, unsolved_valid, stop, overflow
    );

endinterface

// File: rtl/copy_request_receiver_sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO with occupancy count and an almost-full
// flag at DEPTH - MARGIN (margin floored at 2).
module sync_fifo_fwft #(
    parameter int W      = 33,
    parameter int LOG    = 4,
    parameter int MARGIN = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic [LOG:0] count_o,
    output logic         almost_full_o
);

    localparam int           DEPTH      = 1 << LOG;
    localparam int           MARGIN_EFF = (MARGIN < 2) ? 2 : MARGIN;
    localparam logic [LOG:0] FULL_CNT   = (LOG+1)'(DEPTH);
    localparam logic [LOG:0] THRESH     = (LOG+1)'(DEPTH - MARGIN_EFF);

    logic [W-1:0]   mem_q [DEPTH];
    logic [LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG:0]   count_q, count_d;
    logic           do_push, do_pop;

    // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        // A pop frees the slot in the same cycle, so push at full plus pop is accepted.
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q + LOG'(do_push);
        rd_ptr_d = rd_ptr_q + LOG'(do_pop);
        count_d  = count_q + (LOG+1)'(do_push) - (LOG+1)'(do_pop);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which words are live.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o        = mem_q[rd_ptr_q];
    assign valid_o       = (count_q != '0);
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= THRESH);

endmodule

// File: rtl/copy_request_receiver.sv
// BRAM-side endpoint of the copy-token request interface: checks requested bytes against
// a per-line byte-valid table and routes each request to the even, odd or unsolved FIFO.
module copy_request_receiver
    import copy_request_receiver_pkg::*;
#(
    parameter int ADDR_W        = LINE_ADDR_W,
    parameter int FIFO_LOG      = 4,
    parameter int ALMOST_MARGIN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    copy_request_receiver_if.slave  bus
);

    localparam int                LINES    = 1 << ADDR_W;
    localparam logic [FIFO_LOG:0] FULL_CNT = (FIFO_LOG+1)'(1 << FIFO_LOG);

    // S0 request register
    logic              s0_valid_q, s0_valid_d;
    logic [ADDR_W-1:0] s0_addr_q,  s0_addr_d;
    logic [BV_W-1:0]   s0_bv_q,    s0_bv_d;
    logic [OFF_W-1:0]  s0_off_q,   s0_off_d;

    // Table must flush in a single cycle, so it lives in flops rather than block RAM.
    logic [BV_W-1:0]   table_q [LINES];

    logic [BV_W-1:0]   lookup_mask;
    route_e            route;
    token_t            s1_token;

    logic              push_even, push_odd, push_uns;
    logic [FIFO_LOG:0] cnt_even, cnt_odd, cnt_uns;
    logic              af_even, af_odd, af_uns;
    logic              ovf_even, ovf_odd, ovf_uns;

    logic              stop_q, stop_d;
    logic              overflow_q, overflow_d;

    always_comb begin
        s0_valid_d = bus.valid_in && !bus.clear;
        s0_addr_d  = bus.address_in;
        s0_bv_d    = bus.bvalid_in;
        s0_off_d   = bus.offset_in;
    end

    // S1: lookup with same-cycle write bypass, then classify.
    always_comb begin
        lookup_mask = table_q[s0_addr_q];
        if (bus.wr_en && (bus.wr_addr == s0_addr_q)) begin
            lookup_mask = lookup_mask | bus.wr_bvalid;
        end

        route = ROUTE_NONE;
        if (s0_valid_q && !bus.clear) begin
            if ((lookup_mask & s0_bv_q) == s0_bv_q) begin
                route = s0_addr_q[0] ? ROUTE_ODD : ROUTE_EVEN;
            end else begin
                route = ROUTE_UNSOLVED;
            end
        end
    end

    assign s1_token  = pack_token(s0_addr_q, s0_bv_q, s0_off_q);
    assign push_even = (route == ROUTE_EVEN);
    assign push_odd  = (route == ROUTE_ODD);
    assign push_uns  = (route == ROUTE_UNSOLVED);

    // A push into a full FIFO with no pop that cycle is dropped.
    always_comb begin
        ovf_even   = push_even && (cnt_even == FULL_CNT) && !bus.even_rd;
        ovf_odd    = push_odd  && (cnt_odd  == FULL_CNT) && !bus.odd_rd;
        ovf_uns    = push_uns  && (cnt_uns  == FULL_CNT) && !bus.unsolved_rd;
        overflow_d = overflow_q || ovf_even || ovf_odd || ovf_uns;
        stop_d     = !bus.clear && (af_even || af_odd || af_uns);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_addr_q  <= '0;
            s0_bv_q    <= '0;
            s0_off_q   <= '0;
            stop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_addr_q  <= s0_addr_d;
            s0_bv_q    <= s0_bv_d;
            s0_off_q   <= s0_off_d;
            stop_q     <= stop_d;
            overflow_q <= overflow_d;
        end
    end

    // Bits only accumulate; clear wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int i = 0; i < LINES; i++) begin
                table_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            table_q[bus.wr_addr] <= table_q[bus.wr_addr] | bus.wr_bvalid;
        end
    end

    sync_fifo_fwft #(.W(TOKEN_W), .LOG(FIFO_LOG), .MARGIN(ALMOST_MARGIN)) u_even_fifo (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (bus.clear),
        .push_i        (push_even),
        .data_i        (s1_token),
        .pop_i         (bus.even_rd),
        .data_o        (bus.even_data),
        .valid_o       (bus.even_valid),
        .count_o       (cnt_even),
        .almost_full_o (af_even)
    );

    sync_fifo_fwft #(.W(TOKEN_W), .LOG(FIFO_LOG), .MARGIN(ALMOST_MARGIN)) u_odd_fifo (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (bus.clear),
        .push_i        (push_odd),
        .data_i        (s1_token),
        .pop_i         (bus.odd_rd),
        .data_o        (bus.odd_data),
        .valid_o       (bus.odd_valid),
        .count_o       (cnt_odd),
        .almost_full_o (af_odd)
    );

    sync_fifo_fwft #(.W(TOKEN_W), .LOG(FIFO_LOG), .MARGIN(ALMOST_MARGIN)) u_unsolved_fifo (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (bus.clear),
        .push_i        (push_uns),
        .data_i        (s1_token),
        .pop_i         (bus.unsolved_rd),
        .data_o        (bus.unsolved_out),
        .valid_o       (bus.unsolved_valid),
        .count_o       (cnt_uns),
        .almost_full_o (af_uns)
    );

    assign bus.stop     = stop_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_copy_request_receiver.sv
// Directed bench for copy_request_receiver: routing, bypass, backpressure, full/empty
// corner cases, clear and sticky overflow.
module tb_copy_request_receiver;
    import copy_request_receiver_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    copy_request_receiver_if bus ();

    copy_request_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.clear       = 1'b0;
        bus.address_in  = '0;
        bus.bvalid_in   = '0;
        bus.offset_in   = '0;
        bus.valid_in    = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_bvalid   = '0;
        bus.even_rd     = 1'b0;
        bus.odd_rd      = 1'b0;
        bus.unsolved_rd = 1'b0;
    endtask

    task automatic send_req(input logic [8:0] a, input logic [7:0] bv, input logic [15:0] off);
        bus.address_in = a;
        bus.bvalid_in  = bv;
        bus.offset_in  = off;
        bus.valid_in   = 1'b1;
        tick();
        bus.valid_in   = 1'b0;
    endtask

    task automatic write_line(input logic [8:0] a, input logic [7:0] m);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = a;
        bus.wr_bvalid = m;
        tick();
        bus.wr_en     = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({bus.even_valid, bus.odd_valid, bus.unsolved_valid, bus.stop, bus.overflow} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b",
                     {bus.even_valid, bus.odd_valid, bus.unsolved_valid, bus.stop, bus.overflow}, 5'b0);
        end
    endtask

    task automatic test_resolvable();
        write_line(9'h010, 8'hFF);
        send_req(9'h010, 8'h0F, 16'hBEEF);
        total++;
        if (bus.even_valid !== 1'b0) begin
            bad++;
            $display("FAIL resolvable_n1 even_valid got=%b want=0", bus.even_valid);
        end
        tick();
        total++;
        if (bus.even_valid !== 1'b1) begin
            bad++;
            $display("FAIL resolvable_n2 even_valid got=%b want=1", bus.even_valid);
        end
        total++;
        if (bus.even_data !== 33'h0_100F_BEEF) begin
            bad++;
            $display("FAIL resolvable_data got=%h want=%h", bus.even_data, 33'h0_100F_BEEF);
        end
        total++;
        if ({bus.odd_valid, bus.unsolved_valid} !== 2'b00) begin
            bad++;
            $display("FAIL resolvable_others got=%b want=00", {bus.odd_valid, bus.unsolved_valid});
        end
        bus.even_rd = 1'b1;
        tick();
        bus.even_rd = 1'b0;
        total++;
        if (bus.even_valid !== 1'b0) begin
            bad++;
            $display("FAIL resolvable_pop even_valid got=%b want=0", bus.even_valid);
        end
    endtask

    task automatic test_unresolved();
        logic [32:0] exp_tok;
        exp_tok = {9'h011, 8'h03, 16'h1234};
        send_req(9'h011, 8'h03, 16'h1234);
        tick();
        total++;
        if (bus.unsolved_valid !== 1'b1 || bus.unsolved_out !== exp_tok) begin
            bad++;
            $display("FAIL unsolved_entry valid=%b data=%h want valid=1 data=%h",
                     bus.unsolved_valid, bus.unsolved_out, exp_tok);
        end
        total++;
        if ({bus.even_valid, bus.odd_valid} !== 2'b00) begin
            bad++;
            $display("FAIL unsolved_others got=%b want=00", {bus.even_valid, bus.odd_valid});
        end
        bus.unsolved_rd = 1'b1;
        tick();
        bus.unsolved_rd = 1'b0;
        total++;
        if (bus.unsolved_valid !== 1'b0) begin
            bad++;
            $display("FAIL unsolved_pop valid got=%b want=0", bus.unsolved_valid);
        end
        write_line(9'h011, 8'h03);
        send_req(9'h011, 8'h03, 16'h1234);
        tick();
        total++;
        if (bus.odd_valid !== 1'b1 || bus.odd_data !== exp_tok) begin
            bad++;
            $display("FAIL resend_odd valid=%b data=%h want valid=1 data=%h",
                     bus.odd_valid, bus.odd_data, exp_tok);
        end
        total++;
        if ({bus.even_valid, bus.unsolved_valid} !== 2'b00) begin
            bad++;
            $display("FAIL resend_others got=%b want=00", {bus.even_valid, bus.unsolved_valid});
        end
        bus.odd_rd = 1'b1;
        tick();
        bus.odd_rd = 1'b0;
    endtask

    task automatic test_bypass();
        // Full bypass: the write arrives in the same cycle the request is looked up.
        bus.address_in = 9'h020;
        bus.bvalid_in  = 8'h01;
        bus.offset_in  = 16'h0A0A;
        bus.valid_in   = 1'b1;
        tick();
        bus.valid_in   = 1'b0;
        write_line(9'h020, 8'h01);
        total++;
        if (bus.even_valid !== 1'b1 || bus.unsolved_valid !== 1'b0) begin
            bad++;
            $display("FAIL bypass_route even=%b uns=%b want even=1 uns=0",
                     bus.even_valid, bus.unsolved_valid);
        end
        total++;
        if (bus.even_data !== {9'h020, 8'h01, 16'h0A0A}) begin
            bad++;
            $display("FAIL bypass_data got=%h want=%h", bus.even_data, {9'h020, 8'h01, 16'h0A0A});
        end
        bus.even_rd = 1'b1;
        tick();
        bus.even_rd = 1'b0;

        // Partial bypass: only one of the two requested bytes is supplied.
        bus.address_in = 9'h022;
        bus.bvalid_in  = 8'h03;
        bus.offset_in  = 16'h0B0B;
        bus.valid_in   = 1'b1;
        tick();
        bus.valid_in   = 1'b0;
        write_line(9'h022, 8'h01);
        total++;
        if (bus.unsolved_valid !== 1'b1 || bus.even_valid !== 1'b0) begin
            bad++;
            $display("FAIL partial_bypass even=%b uns=%b want even=0 uns=1",
                     bus.even_valid, bus.unsolved_valid);
        end
        bus.unsolved_rd = 1'b1;
        tick();
        bus.unsolved_rd = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        int got;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.stop) break;
            send_req(9'h010, 8'h01, 16'(n));
            n++;
        end
        // Count hits 12 in cycle 13; the registered stop is seen in cycle 14.
        total++;
        if (n !== 14) begin
            bad++;
            $display("FAIL backpressure_sent got=%0d want=14", n);
        end
        tick();
        tick();
        total++;
        if (bus.overflow !== 1'b0 || bus.stop !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_flags ovf=%b stop=%b want ovf=0 stop=1", bus.overflow, bus.stop);
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.even_valid) break;
            total++;
            if (bus.even_data[15:0] !== 16'(i)) begin
                bad++;
                $display("FAIL backpressure_order idx=%0d got=%h want=%h", i, bus.even_data[15:0], 16'(i));
            end
            bus.even_rd = 1'b1;
            tick();
            bus.even_rd = 1'b0;
            got++;
        end
        total++;
        if (got !== 14) begin
            bad++;
            $display("FAIL backpressure_drained got=%0d want=14", got);
        end
        tick();
        total++;
        if (bus.stop !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release stop got=%b want=0", bus.stop);
        end
    endtask

    task automatic test_simultaneous();
        int got;
        for (int i = 0; i < 16; i++) begin
            send_req(9'h010, 8'h01, 16'(i));
        end
        tick();
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL fill16_overflow got=%b want=0", bus.overflow);
        end
        send_req(9'h010, 8'h01, 16'd16);
        bus.even_rd = 1'b1;
        tick();
        bus.even_rd = 1'b0;
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL push_pop_full overflow got=%b want=0", bus.overflow);
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.even_valid) break;
            total++;
            if (bus.even_data[15:0] !== 16'(i + 1)) begin
                bad++;
                $display("FAIL push_pop_order idx=%0d got=%h want=%h", i, bus.even_data[15:0], 16'(i + 1));
            end
            bus.even_rd = 1'b1;
            tick();
            bus.even_rd = 1'b0;
            got++;
        end
        total++;
        if (got !== 16) begin
            bad++;
            $display("FAIL push_pop_count got=%0d want=16", got);
        end
        bus.even_rd = 1'b1;
        tick();
        bus.even_rd = 1'b0;
        total++;
        if (bus.even_valid !== 1'b0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL pop_empty valid=%b ovf=%b want 0 0", bus.even_valid, bus.overflow);
        end
        send_req(9'h010, 8'h01, 16'h0055);
        tick();
        total++;
        if (bus.even_valid !== 1'b1 || bus.even_data[15:0] !== 16'h0055) begin
            bad++;
            $display("FAIL after_empty_pop valid=%b off=%h want valid=1 off=0055",
                     bus.even_valid, bus.even_data[15:0]);
        end
        bus.even_rd = 1'b1;
        tick();
        bus.even_rd = 1'b0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 12; i++) begin
            send_req(9'h010, 8'h01, 16'(i));
        end
        tick();
        tick();
        total++;
        if (bus.stop !== 1'b1) begin
            bad++;
            $display("FAIL clear_pre_stop got=%b want=1", bus.stop);
        end
        send_req(9'h010, 8'h01, 16'd100);
        send_req(9'h011, 8'h01, 16'd101);
        send_req(9'h012, 8'h01, 16'd102);
        bus.clear     = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 9'h030;
        bus.wr_bvalid = 8'hFF;
        tick();
        bus.clear     = 1'b0;
        bus.wr_en     = 1'b0;
        total++;
        if ({bus.even_valid, bus.odd_valid, bus.unsolved_valid, bus.stop} !== 4'b0) begin
            bad++;
            $display("FAIL clear_outputs got=%b want=0000",
                     {bus.even_valid, bus.odd_valid, bus.unsolved_valid, bus.stop});
        end
        tick();
        tick();
        total++;
        if ({bus.even_valid, bus.odd_valid, bus.unsolved_valid, bus.overflow} !== 4'b0) begin
            bad++;
            $display("FAIL clear_inflight got=%b want=0000",
                     {bus.even_valid, bus.odd_valid, bus.unsolved_valid, bus.overflow});
        end
        // Table lines written before and during clear must both read as empty now.
        send_req(9'h010, 8'h01, 16'd200);
        send_req(9'h030, 8'h01, 16'd201);
        tick();
        total++;
        if (bus.even_valid !== 1'b0 || bus.unsolved_out !== {9'h010, 8'h01, 16'd200}) begin
            bad++;
            $display("FAIL clear_table_a even=%b uns=%h want even=0 uns=%h",
                     bus.even_valid, bus.unsolved_out, {9'h010, 8'h01, 16'd200});
        end
        bus.unsolved_rd = 1'b1;
        tick();
        bus.unsolved_rd = 1'b0;
        total++;
        if (bus.unsolved_valid !== 1'b1 || bus.unsolved_out !== {9'h030, 8'h01, 16'd201}) begin
            bad++;
            $display("FAIL clear_table_b valid=%b uns=%h want valid=1 uns=%h",
                     bus.unsolved_valid, bus.unsolved_out, {9'h030, 8'h01, 16'd201});
        end
        bus.unsolved_rd = 1'b1;
        tick();
        bus.unsolved_rd = 1'b0;
        total++;
        if (bus.unsolved_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_table_empty valid got=%b want=0", bus.unsolved_valid);
        end
    endtask

    task automatic test_overflow();
        write_line(9'h010, 8'hFF);
        for (int i = 0; i < 17; i++) begin
            send_req(9'h010, 8'h01, 16'(i));
        end
        tick();
        total++;
        if (bus.overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set got=%b want=1", bus.overflow);
        end
        total++;
        if (bus.even_data[15:0] !== 16'd0) begin
            bad++;
            $display("FAIL overflow_head got=%h want=0000", bus.even_data[15:0]);
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        total++;
        if (bus.overflow !== 1'b1 || bus.even_valid !== 1'b0) begin
            bad++;
            $display("FAIL overflow_sticky ovf=%b valid=%b want ovf=1 valid=0", bus.overflow, bus.even_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_rst got=%b want=0", bus.overflow);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_resolvable();
        test_unresolved();
        test_bypass();
        test_backpressure();
        test_simultaneous();
        test_clear();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
